// File: rtl/cnn_pkg.sv
// Shared CNN-engine definitions: result-memory bank selects, layer-1 pooling FSM states, default map size.
// Optional rounding of pooled values is controlled by MAXPOOL_CEIL_EN in maxpool_cmp.
package cnn_pkg;

  localparam int IMG_W_DEF = 64;
  localparam int FRAC_W    = 16;

  localparam logic [2:0] CSEL_NONE  = 3'd0;
  localparam logic [2:0] CSEL_L0_K0 = 3'd1;
  localparam logic [2:0] CSEL_L0_K1 = 3'd2;
  localparam logic [2:0] CSEL_L1_K0 = 3'd3;
  localparam logic [2:0] CSEL_L1_K1 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WR,
    ST_FIN
  } pool_state_t;

endpackage

// File: rtl/l0_maxpool_if.sv
// Result-memory port: one-cycle-latency read side plus write side, with bank select.
// The pooler is the master; memory answers reads the cycle after crd and has no backpressure.
interface l0_maxpool_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
);

  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic [2:0]        csel;

  modport master (
    output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/maxpool_cmp.sv
// Running max over one 2x2 window; register updates the cycle a datum arrives, output is combinational.
// No backpressure; MAXPOOL_CEIL_EN rounds the output up to an integer with saturation at the top integer.
module maxpool_cmp
  import cnn_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              upd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] max_q;

  // First datum of a window overwrites unconditionally so no per-window clear is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
    end else if (load) begin
      max_q <= din;
    end else if (upd && (din > max_q)) begin
      max_q <= din;
    end
  end

`ifdef MAXPOOL_CEIL_EN
  localparam int INT_W = DATA_W - FRAC_W;

  logic [INT_W-1:0]  int_part;
  logic [FRAC_W-1:0] frac_part;
  logic [INT_W-1:0]  int_inc;

  assign int_part  = max_q[DATA_W-1:FRAC_W];
  assign frac_part = max_q[FRAC_W-1:0];
  assign int_inc   = int_part + INT_W'(1);

  always_comb begin
    dout = max_q;
    if (frac_part != '0) begin
      if (&int_part) begin
        dout = {int_part, {FRAC_W{1'b0}}};
      end else begin
        dout = {int_inc, {FRAC_W{1'b0}}};
      end
    end
  end
`else
  assign dout = max_q;
`endif

endmodule

// File: rtl/l0_maxpool.sv
// Layer-1 2x2/stride-2 max-pool over both layer-0 maps: 6 cycles per output pixel, start-to-done 12289 cycles.
// No backpressure; start is only honoured in IDLE. MAXPOOL_CEIL_EN (in maxpool_cmp) rounds written values up.
module l0_maxpool
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  l0_maxpool_if.master  mem
);

  localparam int OW = IMG_W / 2;
  localparam int OB = $clog2(OW);

  pool_state_t       state, state_nxt;
  logic [1:0]        k;
  logic [OB-1:0]     orow;
  logic [OB-1:0]     ocol;
  logic              ch;
  logic              last_pix;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              mx_load;
  logic              mx_upd;
  logic [DATA_W-1:0] mx_val;

  assign last_pix = (&orow) && (&ocol);
  // Power-of-two map: (2*orow+k1)*IMG_W + 2*ocol+k0 is a plain bit concatenation.
  assign rd_addr  = ADDR_W'({orow, k[1], ocol, k[0]});
  assign wr_addr  = ADDR_W'({orow, ocol});

  // Datum requested at k arrives at k+1; the k=3 datum lands in CMP.
  assign mx_load = (state == ST_RD) && (k == 2'd1);
  assign mx_upd  = ((state == ST_RD) && k[1]) || (state == ST_CMP);

  maxpool_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk   (clk),
    .reset (reset),
    .load  (mx_load),
    .upd   (mx_upd),
    .din   (mem.cdata_rd),
    .dout  (mx_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k    <= '0;
      orow <= '0;
      ocol <= '0;
      ch   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            k    <= '0;
            orow <= '0;
            ocol <= '0;
            ch   <= 1'b0;
          end
        end
        ST_RD: k <= k + 2'd1;
        ST_WR: begin
          ocol <= ocol + 1'b1;
          if (&ocol) begin
            orow <= orow + 1'b1;
          end
          if (last_pix) begin
            ch <= ~ch;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    mem.crd      = 1'b0;
    mem.caddr_rd = '0;
    mem.cwr      = 1'b0;
    mem.caddr_wr = '0;
    mem.cdata_wr = '0;
    mem.csel     = CSEL_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        busy         = 1'b1;
        mem.crd      = 1'b1;
        mem.caddr_rd = rd_addr;
        mem.csel     = ch ? CSEL_L0_K1 : CSEL_L0_K0;
        if (k == 2'd3) begin
          state_nxt = ST_CMP;
        end
      end
      ST_CMP: begin
        busy      = 1'b1;
        mem.csel  = ch ? CSEL_L0_K1 : CSEL_L0_K0;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        busy         = 1'b1;
        mem.cwr      = 1'b1;
        mem.caddr_wr = wr_addr;
        mem.cdata_wr = mx_val;
        mem.csel     = ch ? CSEL_L1_K1 : CSEL_L1_K0;
        state_nxt    = (last_pix && ch) ? ST_FIN : ST_RD;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
